// File: rtl/id_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_controller_if
// Description : Bundle between the decode stage and the hazard controller.
//               master = decode side (drives instruction fields, branch and
//               memory-stall status); slave = hazard controller (drives
//               pipeline enables, flush/bubble, bypass and forwarding selects
//               and the performance counters).
// Revision    : 1.0 - initial release
// ============================================================================
interface id_hazard_controller_if #(
    parameter int CNT_W = 16
);
    // decode-stage instruction fields and pipeline status
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_wr_en;
    logic             id_mem_r;
    logic             branch_taken;
    logic             mem_stall;

    // sequencing results
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             id_wb_bypass_a;
    logic             id_wb_bypass_b;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr_en, id_mem_r, branch_taken, mem_stall,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble,
               id_wb_bypass_a, id_wb_bypass_b, fwd_a, fwd_b,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr_en, id_mem_r, branch_taken, mem_stall,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble,
               id_wb_bypass_a, id_wb_bypass_b, fwd_a, fwd_b,
               stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_controller
// Description : Hazard/sequencing controller for the 5-stage RISC-V core.
//               Tracks destination registers of instructions in EX, MEM and
//               WB; generates PC/IF-ID enables, IF/ID flush, ID/EX bubble,
//               decode write-back bypass and registered EX forwarding
//               selects; keeps saturating stall and flush counters.
// Ports       : clk   - core clock, rising edge
//               reset - asynchronous, active-high
//               hz    - id_hazard_controller_if.slave (decode fields in,
//                       sequencing controls and counters out)
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_controller #(
    parameter int CNT_W = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    id_hazard_controller_if.slave hz
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } slot_t;

    localparam slot_t            c_EMPTY_SLOT = '0;
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;

    slot_t            ex_q, ex_d;
    slot_t            mem_q, mem_d;
    slot_t            wb_q, wb_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             w_load_use;
    slot_t            w_new_slot;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic slot_writes(input slot_t s, input logic [4:0] r);
        return s.valid && s.wr && (s.rd == r) && (r != 5'd0);
    endfunction

    // Nearest producer wins: EX (one ahead) beats MEM (two ahead).
    function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                           input logic [4:0] r);
        if (slot_writes(ex_s, r))
            return 2'b01;
        else if (slot_writes(mem_s, r))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_load_use = ex_q.load &&
                     ((hz.id_use_rs1 && slot_writes(ex_q, hz.id_rs1)) ||
                      (hz.id_use_rs2 && slot_writes(ex_q, hz.id_rs2)));

        w_new_slot = '{valid: hz.id_valid, rd: hz.id_rd,
                       wr: hz.id_wr_en, load: hz.id_mem_r};

        // defaults: normal issue, state holds
        hz.pc_en        = 1'b1;
        hz.if_id_en     = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        ex_d            = ex_q;
        mem_d           = mem_q;
        wb_d            = wb_q;
        fwd_a_d         = fwd_a_q;
        fwd_b_d         = fwd_b_q;
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;

        if (hz.mem_stall) begin
            // whole pipeline frozen; only the stall counter moves
            hz.pc_en    = 1'b0;
            hz.if_id_en = 1'b0;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (hz.branch_taken) begin
                // kill both the fetched and the decoded instruction
                hz.if_id_flush  = 1'b1;
                hz.id_ex_bubble = 1'b1;
                ex_d            = c_EMPTY_SLOT;
                fwd_a_d         = 2'b00;
                fwd_b_d         = 2'b00;
                flush_cnt_d     = sat_inc(flush_cnt_q);
            end else if (w_load_use) begin
                // hold PC and IF/ID, insert one bubble behind the load
                hz.pc_en        = 1'b0;
                hz.if_id_en     = 1'b0;
                hz.id_ex_bubble = 1'b1;
                ex_d            = c_EMPTY_SLOT;
                fwd_a_d         = 2'b00;
                fwd_b_d         = 2'b00;
                stall_cnt_d     = sat_inc(stall_cnt_q);
            end else begin
                ex_d = w_new_slot;
                // an empty decode slot enters EX as a bubble with no forwarding
                fwd_a_d = hz.id_valid ? fwd_sel(ex_q, mem_q, hz.id_rs1) : 2'b00;
                fwd_b_d = hz.id_valid ? fwd_sel(ex_q, mem_q, hz.id_rs2) : 2'b00;
            end
        end
    end

    // The register file is written in WB during the same cycle decode reads it.
    always_comb begin
        hz.id_wb_bypass_a = hz.id_use_rs1 && slot_writes(wb_q, hz.id_rs1);
        hz.id_wb_bypass_b = hz.id_use_rs2 && slot_writes(wb_q, hz.id_rs2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= c_EMPTY_SLOT;
            mem_q       <= c_EMPTY_SLOT;
            wb_q        <= c_EMPTY_SLOT;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.fwd_a     = fwd_a_q;
    assign hz.fwd_b     = fwd_b_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_hazard_controller
// Description : Self-checking bench for id_hazard_controller. Directed
//               instruction sequences followed by random traffic, all
//               compared each cycle against a pipeline model kept as an
//               array of in-flight instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_hazard_controller;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_hazard_controller_if #(.CNT_W(CNT_W)) hz ();

    id_hazard_controller #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int checks   = 0;
    int failures = 0;

    // model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } mslot_t;

    mslot_t pipe[3];
    int     m_fa, m_fb, m_sc, m_fc;

    // current decode-stage inputs as the bench drove them
    bit c_v, c_u1, c_u2, c_wr, c_ld, c_br, c_ms;
    int c_rs1, c_rs2, c_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit hits(input mslot_t s, input int r);
        return s.v && s.wr && (r != 0) && (s.rd == r);
    endfunction

    function automatic int producer(input int r);
        if (hits(pipe[0], r)) return 1;   // result sits in MEM next cycle
        if (hits(pipe[1], r)) return 2;   // result sits in WB next cycle
        return 0;
    endfunction

    function automatic bit load_use_now();
        return pipe[0].ld && ((c_u1 && hits(pipe[0], c_rs1)) ||
                              (c_u2 && hits(pipe[0], c_rs2)));
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2,
                         input bit u2, input int rd, input bit wr, input bit ld,
                         input bit br, input bit ms);
        c_v = v; c_rs1 = rs1; c_u1 = u1; c_rs2 = rs2; c_u2 = u2;
        c_rd = rd; c_wr = wr; c_ld = ld; c_br = br; c_ms = ms;
        hz.id_valid     = v;
        hz.id_rs1       = rs1[4:0];
        hz.id_use_rs1   = u1;
        hz.id_rs2       = rs2[4:0];
        hz.id_use_rs2   = u2;
        hz.id_rd        = rd[4:0];
        hz.id_wr_en     = wr;
        hz.id_mem_r     = ld;
        hz.branch_taken = br;
        hz.mem_stall    = ms;
        #2;
    endtask

    task automatic model_check();
        bit lu, e_pc, e_ifid, e_flush, e_bub;
        lu      = load_use_now();
        e_pc    = !c_ms && (c_br || !lu);
        e_ifid  = !c_ms && !lu;
        e_flush = !c_ms && c_br;
        e_bub   = !c_ms && (c_br || lu);
        chk("pc_en",        32'(hz.pc_en),        32'(e_pc));
        if (c_ms || !c_br)
            chk("if_id_en", 32'(hz.if_id_en),     32'(e_ifid));
        chk("if_id_flush",  32'(hz.if_id_flush),  32'(e_flush));
        chk("id_ex_bubble", 32'(hz.id_ex_bubble), 32'(e_bub));
        chk("bypass_a",     32'(hz.id_wb_bypass_a), 32'(c_u1 && hits(pipe[2], c_rs1)));
        chk("bypass_b",     32'(hz.id_wb_bypass_b), 32'(c_u2 && hits(pipe[2], c_rs2)));
        chk("fwd_a",        32'(hz.fwd_a),        m_fa);
        chk("fwd_b",        32'(hz.fwd_b),        m_fb);
        chk("stall_cnt",    32'(hz.stall_cnt),    m_sc);
        chk("flush_cnt",    32'(hz.flush_cnt),    m_fc);
    endtask

    // compare, then advance one clock and move the model along with it
    task automatic tick();
        bit     lu, issue;
        mslot_t nxt;
        int     nfa, nfb;
        model_check();
        lu    = load_use_now();
        issue = c_v && !lu && !c_br;
        nxt   = '{c_v && !lu && !c_br, c_rd, c_wr, c_ld};
        nfa   = issue ? producer(c_rs1) : 0;
        nfb   = issue ? producer(c_rs2) : 0;
        @(posedge clk);
        #1;
        if (c_ms) begin
            m_sc = sat(m_sc);
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
            m_fa = nfa;
            m_fb = nfb;
            if (c_br)      m_fc = sat(m_fc);
            else if (lu)   m_sc = sat(m_sc);
        end
    endtask

    task automatic cycle(input bit v, input int rs1, input bit u1, input int rs2,
                         input bit u2, input int rd, input bit wr, input bit ld,
                         input bit br, input bit ms);
        drive(v, rs1, u1, rs2, u2, rd, wr, ld, br, ms);
        tick();
    endtask

    task automatic nop();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_pc_en"},    32'(hz.pc_en),          1);
        chk({pfx, "_if_id_en"}, 32'(hz.if_id_en),       1);
        chk({pfx, "_flush"},    32'(hz.if_id_flush),    0);
        chk({pfx, "_bubble"},   32'(hz.id_ex_bubble),   0);
        chk({pfx, "_byp_a"},    32'(hz.id_wb_bypass_a), 0);
        chk({pfx, "_byp_b"},    32'(hz.id_wb_bypass_b), 0);
        chk({pfx, "_fwd_a"},    32'(hz.fwd_a),          0);
        chk({pfx, "_fwd_b"},    32'(hz.fwd_b),          0);
        chk({pfx, "_stall"},    32'(hz.stall_cnt),      0);
        chk({pfx, "_flushc"},   32'(hz.flush_cnt),      0);
    endtask

    // assert reset asynchronously (away from a clock edge) with inputs low
    task automatic async_reset(input string pfx);
        reset = 1'b1;
        c_v = 0; c_u1 = 0; c_u2 = 0; c_wr = 0; c_ld = 0; c_br = 0; c_ms = 0;
        c_rs1 = 0; c_rs2 = 0; c_rd = 0;
        hz.id_valid = 0; hz.id_rs1 = '0; hz.id_use_rs1 = 0; hz.id_rs2 = '0;
        hz.id_use_rs2 = 0; hz.id_rd = '0; hz.id_wr_en = 0; hz.id_mem_r = 0;
        hz.branch_taken = 0; hz.mem_stall = 0;
        #1;
        check_reset_values(pfx);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    int base_sc;

    initial begin
        model_reset();
        #3;
        async_reset("rst0");

        // back-to-back: add x5 ; sub x6,x5,x5
        cycle(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
        drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
        chk("b2b_pc_en", 32'(hz.pc_en), 1);
        tick();
        chk("b2b_fwd_a", 32'(hz.fwd_a), 1);
        chk("b2b_fwd_b", 32'(hz.fwd_b), 1);

        // one-gap: add x5 ; nop ; or x7,x5,x0
        cycle(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
        nop();
        cycle(1, 5, 1, 0, 1, 7, 1, 0, 0, 0);
        chk("gap_fwd_a", 32'(hz.fwd_a), 2);
        chk("gap_fwd_b", 32'(hz.fwd_b), 0);

        // load-use: lw x3 ; add x4,x3,x1
        async_reset("rst1");
        cycle(1, 2, 1, 0, 0, 3, 1, 1, 0, 0);
        drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
        chk("lu_pc_en",  32'(hz.pc_en),        0);
        chk("lu_ifid",   32'(hz.if_id_en),     0);
        chk("lu_bubble", 32'(hz.id_ex_bubble), 1);
        tick();
        chk("lu_stall_cnt", 32'(hz.stall_cnt), 1);
        drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
        chk("lu_reissue_pc_en", 32'(hz.pc_en), 1);
        tick();
        chk("lu_fwd_a", 32'(hz.fwd_a), 2);
        chk("lu_fwd_b", 32'(hz.fwd_b), 0);

        // writes to x0
        cycle(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 1, 2, 1, 0, 0, 0);
        chk("x0_byp_a", 32'(hz.id_wb_bypass_a), 0);
        tick();
        chk("x0_fwd_a", 32'(hz.fwd_a), 0);
        chk("x0_fwd_b", 32'(hz.fwd_b), 0);
        cycle(1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        drive(1, 0, 1, 0, 1, 8, 1, 0, 0, 0);
        chk("x0_lw_no_stall", 32'(hz.pc_en), 1);
        tick();

        // branch beats a pending load-use, then a 3-cycle memory stall
        async_reset("rst2");
        cycle(1, 2, 1, 0, 0, 3, 1, 1, 0, 0);
        drive(1, 3, 1, 0, 0, 4, 1, 0, 1, 0);
        chk("br_flush",  32'(hz.if_id_flush),  1);
        chk("br_bubble", 32'(hz.id_ex_bubble), 1);
        chk("br_pc_en",  32'(hz.pc_en),        1);
        tick();
        chk("br_flush_cnt", 32'(hz.flush_cnt), 1);
        chk("br_stall_cnt", 32'(hz.stall_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 1, 3, 1, 4, 1, 0, 0, 1);
            chk("ms_pc_en", 32'(hz.pc_en),    0);
            chk("ms_ifid",  32'(hz.if_id_en), 0);
            tick();
        end
        chk("ms_stall_cnt", 32'(hz.stall_cnt), 3);

        // WB bypass: add x9 ; nop ; nop ; decode rs2=x9
        cycle(1, 1, 1, 2, 1, 9, 1, 0, 0, 0);
        nop();
        nop();
        drive(1, 1, 1, 9, 1, 10, 1, 0, 0, 0);
        chk("wb_byp_b", 32'(hz.id_wb_bypass_b), 1);
        tick();

        // reset in the middle of a load-use stall
        cycle(1, 1, 1, 0, 0, 3, 1, 1, 0, 0);
        drive(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
        async_reset("rst_mid");
        cycle(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
        chk("post_rst_fwd_a", 32'(hz.fwd_a), 0);

        // saturation of both counters
        async_reset("rst3");
        for (int i = 0; i < CMAX + 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("sat_stall", 32'(hz.stall_cnt), CMAX);
        for (int i = 0; i < CMAX + 4; i++) cycle(1, 1, 1, 2, 1, 3, 1, 0, 1, 0);
        chk("sat_flush", 32'(hz.flush_cnt), CMAX);

        // random traffic over a small register range to provoke hazards
        async_reset("rst4");
        base_sc = 0;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) != 0, int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            if (i == 200) begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                async_reset("rst_rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/id_hazard_controller.md
# id_hazard_controller

Pipeline sequencing block for the 5-stage RISC-V core. It sits beside the instruction decode unit and tracks the destination registers of instructions in flight in EX, MEM and WB. From that state it drives PC/IF-ID enables, ID/EX bubble insertion, IF/ID flush, decode-stage register-file bypass and EX-stage forwarding selects. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  5  source register fields (instruction[19:15], [24:20])
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_rd  in  5  destination field (instruction[11:7])
- id_wr_en  in  1  write_reg_en from controller
- id_mem_r  in  1  d_mem_r from controller (load)
- branch_taken  in  1  instruction in EX resolved as taken branch/jump
- mem_stall  in  1  data memory busy; whole pipeline must freeze
- pc_en  out  1  PC may advance
- if_id_en  out  1  IF/ID register may load
- if_id_flush  out  1  IF/ID register loads a NOP
- id_ex_bubble  out  1  ID/EX register loads a NOP
- id_wb_bypass_a, id_wb_bypass_b  out  1  decode data_1/data_2 takes write-back data instead of the register-file read
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM-stage ALU result, 10 WB-stage result
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- Internal slots EX, MEM, WB; each holds {valid, rd, wr, load}. A slot "writes r" when valid && wr && rd==r && r!=0. x0 never matches.
- issue = id_valid && !load_use && !branch_taken.
- load_use = EX.valid && EX.load && EX.wr && EX.rd!=0 && ((id_use_rs1 && id_rs1==EX.rd) || (id_use_rs2 && id_rs2==EX.rd)).
- Priority: mem_stall > branch_taken > load_use.
- mem_stall=1: all slots, fwd regs and counters hold, except stall_cnt, which increments. Outputs: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_bubble=0.
- branch_taken (no mem_stall): pc_en=1, if_id_flush=1, id_ex_bubble=1. EX receives an invalid slot. flush_cnt++.
- load_use (no stall, no branch): pc_en=0, if_id_en=0, id_ex_bubble=1. EX receives an invalid slot. stall_cnt++.
- Otherwise: pc_en=1, if_id_en=1. EX receives {id_valid, id_rd, id_wr_en, id_mem_r}.
- When the pipeline is not stalled, slots shift: WB<=MEM, MEM<=EX, EX<=new.
- fwd_a/fwd_b are registered and loaded together with EX. Source rs1 selects:
  - 01 if the current EX slot writes rs1.
  - Else 10 if the current MEM slot writes rs1.
  - Else 00.
  - rs2 follows the same rule. A bubble loads 00.
- id_wb_bypass_a = id_use_rs1 && the WB slot writes id_rs1. The b output follows the same rule for rs2. Both are combinational.
- Counters saturate at all-ones; they do not wrap.

## Timing
- Reset values: all slots invalid, fwd_a=fwd_b=00, stall_cnt=flush_cnt=0. With reset high and inputs low: pc_en=1, if_id_en=1, all flush/bubble/bypass outputs 0.
- pc_en, if_id_en, if_id_flush, id_ex_bubble and bypass outputs are combinational from the current slots and inputs; there is no added latency.
- Forwarding selects are valid in the cycle the instruction occupies EX (one cycle after issue).
- Load-use costs exactly one bubble cycle. Next cycle the load is in MEM, and the dependent instruction issues with fwd=10 (load data from WB) after one more shift.
- Taken branch costs two cycles: the flushed IF/ID instruction plus the killed ID instruction.
- Branch and load_use in the same cycle: branch wins; no stall_cnt increment.
- Reset asserted mid-stall or mid-flush: outputs return to reset values immediately (async). The first instruction after deassert issues with fwd=00.

## Test plan
- Back-to-back ALU ops: `add x5` then `sub x6,x5,x5` -> no stall; second op in EX sees fwd_a=fwd_b=01.
- One-gap dependency: `add x5`, `nop`, `or x7,x5,x0` -> fwd_a=10, fwd_b=00.
- Load-use: `lw x3`, `add x4,x3,x1` -> one cycle pc_en=0, if_id_en=0, id_ex_bubble=1, stall_cnt=1; then the add issues and in EX sees fwd_a=10.
- Writes to x0: `addi x0`, then `add x2,x0,x0` -> fwd 00, no bypass. `lw x0`, then a use of x0 -> no stall.
- branch_taken while load_use is also pending -> if_id_flush=1, id_ex_bubble=1, pc_en=1, flush_cnt=1, stall_cnt unchanged. Then hold mem_stall 3 cycles -> enables 0, slots frozen, stall_cnt+3.
- WB bypass: `add x9` followed two slots later by a decode of rs2=x9 -> id_wb_bypass_b=1 in that cycle. Assert reset mid-sequence -> all fwd/counters 0 at once.
